draw_port_arbiter: RTL and testbench
====================================

DRAW_PORT_ARBITER -- requirements
Module: draw_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters sharing the framebuffer pixel-write port (2..8).
REQ-002 Parameter X_W, default 8, pixel x-coordinate width.
REQ-003 Parameter Y_W, default 7, pixel y-coordinate width.
REQ-004 Parameter C_W, default 3, colour width.
REQ-005 Parameter MAX_HOLD, default 255, grant cycles before forced preemption when others wait; 0 disables preemption.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 program_reset  input  1  reset, asynchronous, active-high.
REQ-008 req  input  N_REQ  per-requester port request, level-held for the whole burst.
REQ-009 plot_in  input  N_REQ  per-requester pixel-write strobe.
REQ-010 x_in  input  N_REQ*X_W  packed x coordinates, requester i at bits [i*X_W +: X_W].
REQ-011 y_in  input  N_REQ*Y_W  packed y coordinates, same packing.
REQ-012 colour_in  input  N_REQ*C_W  packed colours, same packing.
REQ-013 grant  output  N_REQ  registered one-hot grant; all-zero when no owner.
REQ-014 plot  output  1  pixel-write strobe to the framebuffer.
REQ-015 x  output  X_W  owner's x coordinate.
REQ-016 y  output  Y_W  owner's y coordinate.
REQ-017 colour  output  C_W  owner's colour.
REQ-018 busy  output  1  high when state is not IDLE.
REQ-019 preempted  output  N_REQ  one-cycle one-hot pulse naming the requester whose grant was forcibly removed.
REQ-020 current_state  output  2  FSM state, for debug.

Function
REQ-021 FSM states: IDLE=0, GRANTED=1, TURNAROUND=2; encoding 3 is illegal and transitions to IDLE.
REQ-022 Winner selection: round-robin; search begins at last_owner+1 modulo N_REQ, first asserted req wins.
REQ-023 IDLE: any req high at edge t -> GRANTED, grant = one-hot winner, last_owner = winner, hold counter = 0, all visible from t+1; no req -> stay IDLE.
REQ-024 GRANTED: plot = plot_in[owner]; x/y/colour = owner's slice, combinational from inputs; hold counter increments by 1 per cycle, saturating at MAX_HOLD.
REQ-025 GRANTED: req[owner] low -> TURNAROUND, grant cleared at the next edge.
REQ-026 GRANTED: hold counter = MAX_HOLD, MAX_HOLD != 0, and any other req high -> TURNAROUND; preempted[owner] pulses for exactly the first TURNAROUND cycle.
REQ-027 Owner release and preemption condition true in the same cycle -> treated as release; no preempted pulse.
REQ-028 TURNAROUND lasts exactly one cycle with grant=0 and plot=0; any req high -> GRANTED with round-robin winner; else IDLE.
REQ-029 A previously preempted owner still requesting ranks last in the round-robin order and is re-granted only after every other waiting requester.
REQ-030 plot_in from non-owners is ignored; plot is never high while grant is all-zero.
REQ-031 x/y/colour are 0 when there is no owner.
REQ-032 A req pulse shorter than one cycle in IDLE is not guaranteed to be granted; requesters hold req until they see grant.

Reset
REQ-033 While program_reset is high: state IDLE, grant 0, plot 0, preempted 0, hold counter 0, last_owner N_REQ-1 (requester 0 wins first), busy 0, current_state 0.
REQ-034 Reset during GRANTED drops the grant immediately (asynchronously) with no preempted pulse; arbitration resumes on the first edge after deassertion.

Structure
REQ-035 Package draw_pkg holds the state encodings (IDLE, GRANTED, TURNAROUND) and default coordinate and colour widths, shared with the existing draw controllers.
REQ-036 One combinational sub-module, rr_pick (inputs req and last_owner; output one-hot winner and its index), implements REQ-022.

Verification
REQ-037 Reset, then req=3'b001 -> grant=3'b001 one cycle later; busy=1; plot follows plot_in[0]; x/y/colour equal slice 0.
REQ-038 req=3'b111 held, each requester drops its req after 4 cycles -> grant order 001, 010, 100, each grant separated by one all-zero TURNAROUND cycle.
REQ-039 MAX_HOLD=8, req0 held forever, req1 raised at cycle 2 -> grant0 for 9 cycles, preempted=3'b001 for one cycle, then grant=3'b010.
REQ-040 Owner drops req in the same cycle the hold counter reaches MAX_HOLD -> preempted stays 0.
REQ-041 plot_in=3'b110 while grant=3'b001 and plot_in[0]=0 -> plot=0.
REQ-042 program_reset pulsed mid-GRANTED -> grant=0 and plot=0 immediately without a clock edge; after release, req=3'b110 -> grant=3'b010.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the draw pipeline: arbiter FSM encodings and default
// pixel coordinate / colour widths used by the draw controllers.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  // Index width for a requester count, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_port_arbiter_if.sv
// Framebuffer pixel-write port shared by N_REQ draw requesters.
// The master modport is the requester side; the slave modport is the arbiter.
interface draw_port_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int X_W   = draw_pkg::DEF_X_W,
  parameter int Y_W   = draw_pkg::DEF_Y_W,
  parameter int C_W   = draw_pkg::DEF_C_W
);

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     plot_in;
  logic [N_REQ*X_W-1:0] x_in;
  logic [N_REQ*Y_W-1:0] y_in;
  logic [N_REQ*C_W-1:0] colour_in;

  logic [N_REQ-1:0]     grant;
  logic                 plot;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [C_W-1:0]       colour;
  logic                 busy;
  logic [N_REQ-1:0]     preempted;
  logic [1:0]           current_state;

  modport master (
    output req, plot_in, x_in, y_in, colour_in,
    input  grant, plot, x, y, colour, busy, preempted, current_state
  );

  modport slave (
    input  req, plot_in, x_in, y_in, colour_in,
    output grant, plot, x, y, colour, busy, preempted, current_state
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner selection: search starts one past the last owner and
// wraps modulo N_REQ; the first asserted request wins.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [N_REQ-1:0] o_winner,
  output logic [IDX_W-1:0] o_winner_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_cand;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_winner     = '0;
    o_winner_idx = '0;
    o_valid      = 1'b0;
    w_cand       = '0;
    // The last owner is visited last (k == N_REQ), giving it lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_owner) + k) % N_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_winner_idx     = w_cand;
        o_winner[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// Arbitrates the framebuffer pixel-write port between N_REQ draw requesters
// with round-robin selection, a one-cycle turnaround and hold-time preemption.
module draw_port_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int C_W      = DEF_C_W,
  parameter int MAX_HOLD = 255
) (
  input  logic               clk,
  input  logic               program_reset,
  draw_port_arbiter_if.slave bus
);

  localparam int IDX_W  = idx_width(N_REQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_preempted;
  logic [IDX_W-1:0] r_last_owner;
  logic [HOLD_W-1:0] r_hold;

  logic [N_REQ-1:0] w_winner;
  logic [IDX_W-1:0] w_winner_idx;
  logic             w_any_req;
  logic             w_owner_req;
  logic             w_others_waiting;
  logic             w_preempt;
  logic             w_plot;
  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic [C_W-1:0]   w_colour;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req        (bus.req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_winner_idx (w_winner_idx),
    .o_valid      (w_any_req)
  );

  assign w_owner_req      = |(bus.req & r_grant);
  assign w_others_waiting = |(bus.req & ~r_grant);
  assign w_preempt        = (MAX_HOLD != 0) && (r_hold == HOLD_MAX) && w_others_waiting;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_preempted  <= '0;
      r_hold       <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
    end else begin
      r_preempted <= '0;
      case (r_state)
        IDLE, TURNAROUND: begin
          if (w_any_req) begin
            r_state      <= GRANTED;
            r_grant      <= w_winner;
            r_last_owner <= w_winner_idx;
            r_hold       <= '0;
          end else begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        GRANTED: begin
          // Release is checked first so a simultaneous drop never reports preemption.
          if (!w_owner_req) begin
            r_state <= TURNAROUND;
            r_grant <= '0;
          end else if (w_preempt) begin
            r_state     <= TURNAROUND;
            r_grant     <= '0;
            r_preempted <= r_grant;
          end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Owner data path keyed on the registered grant, so reset blanks it at once.
  always_comb begin
    w_plot   = |(r_grant & bus.plot_in);
    w_x      = '0;
    w_y      = '0;
    w_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_x      = bus.x_in[i*X_W +: X_W];
        w_y      = bus.y_in[i*Y_W +: Y_W];
        w_colour = bus.colour_in[i*C_W +: C_W];
      end
    end
  end

  assign bus.grant         = r_grant;
  assign bus.plot          = w_plot;
  assign bus.x             = w_x;
  assign bus.y             = w_y;
  assign bus.colour        = w_colour;
  assign bus.busy          = (r_state != IDLE);
  assign bus.preempted     = r_preempted;
  assign bus.current_state = r_state;

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter: a vector table on a default instance
// plus hand sequences for preemption and asynchronous reset on a short-hold one.
module tb_draw_port_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] plot_in;
    logic [2:0] grant;
    logic       plot;
    logic       busy;
    logic [1:0] state;
  } vec_t;

  logic clk;
  logic program_reset;
  int   n_tests;
  int   n_fail;

  logic [23:0] x_all;
  logic [20:0] y_all;
  logic [8:0]  c_all;

  vec_t vec [27];

  draw_port_arbiter_if #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(3)) bus_a ();
  draw_port_arbiter_if #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(3)) bus_b ();

  draw_port_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(3), .MAX_HOLD(255)) dut_a (
    .clk           (clk),
    .program_reset (program_reset),
    .bus           (bus_a)
  );

  draw_port_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(3), .MAX_HOLD(8)) dut_b (
    .clk           (clk),
    .program_reset (program_reset),
    .bus           (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_x(input logic [2:0] g);
    exp_x = 8'h0;
    for (int i = 0; i < N; i++) if (g[i]) exp_x = x_all[i*8 +: 8];
  endfunction

  function automatic logic [6:0] exp_y(input logic [2:0] g);
    exp_y = 7'h0;
    for (int i = 0; i < N; i++) if (g[i]) exp_y = y_all[i*7 +: 7];
  endfunction

  function automatic logic [2:0] exp_c(input logic [2:0] g);
    exp_c = 3'h0;
    for (int i = 0; i < N; i++) if (g[i]) exp_c = c_all[i*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [2:0] g, input logic p,
                         input logic b, input logic [1:0] s);
    check({tag, " grant"},     32'(bus_a.grant), 32'(g));
    check({tag, " plot"},      32'(bus_a.plot), 32'(p));
    check({tag, " x"},         32'(bus_a.x), 32'(exp_x(g)));
    check({tag, " y"},         32'(bus_a.y), 32'(exp_y(g)));
    check({tag, " colour"},    32'(bus_a.colour), 32'(exp_c(g)));
    check({tag, " busy"},      32'(bus_a.busy), 32'(b));
    check({tag, " state"},     32'(bus_a.current_state), 32'(s));
    check({tag, " preempted"}, 32'(bus_a.preempted), 32'd0);
  endtask

  task automatic check_b(input string tag, input logic [2:0] g, input logic [2:0] pre,
                         input logic [1:0] s);
    check({tag, " grant"},     32'(bus_b.grant), 32'(g));
    check({tag, " preempted"}, 32'(bus_b.preempted), 32'(pre));
    check({tag, " state"},     32'(bus_b.current_state), 32'(s));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    x_all = {8'hC2, 8'hB1, 8'hA0};
    y_all = {7'h32, 7'h21, 7'h10};
    c_all = {3'd6, 3'd5, 3'd4};

    // {req, plot_in, grant, plot, busy, state}; outputs observed after the edge.
    vec[0]  = '{3'b111, 3'b111, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[1]  = '{3'b111, 3'b111, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[2]  = '{3'b111, 3'b111, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[3]  = '{3'b111, 3'b111, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[4]  = '{3'b110, 3'b111, 3'b000, 1'b0, 1'b1, 2'd2};
    vec[5]  = '{3'b110, 3'b111, 3'b010, 1'b1, 1'b1, 2'd1};
    vec[6]  = '{3'b110, 3'b111, 3'b010, 1'b1, 1'b1, 2'd1};
    vec[7]  = '{3'b110, 3'b111, 3'b010, 1'b1, 1'b1, 2'd1};
    vec[8]  = '{3'b110, 3'b111, 3'b010, 1'b1, 1'b1, 2'd1};
    vec[9]  = '{3'b100, 3'b111, 3'b000, 1'b0, 1'b1, 2'd2};
    vec[10] = '{3'b100, 3'b111, 3'b100, 1'b1, 1'b1, 2'd1};
    vec[11] = '{3'b100, 3'b111, 3'b100, 1'b1, 1'b1, 2'd1};
    vec[12] = '{3'b100, 3'b111, 3'b100, 1'b1, 1'b1, 2'd1};
    vec[13] = '{3'b100, 3'b111, 3'b100, 1'b1, 1'b1, 2'd1};
    vec[14] = '{3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 2'd2};
    vec[15] = '{3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0};
    vec[16] = '{3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[17] = '{3'b001, 3'b000, 3'b001, 1'b0, 1'b1, 2'd1};
    vec[18] = '{3'b001, 3'b110, 3'b001, 1'b0, 1'b1, 2'd1};
    vec[19] = '{3'b001, 3'b101, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[20] = '{3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 2'd2};
    vec[21] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0};
    vec[22] = '{3'b101, 3'b111, 3'b100, 1'b1, 1'b1, 2'd1};
    vec[23] = '{3'b001, 3'b111, 3'b000, 1'b0, 1'b1, 2'd2};
    vec[24] = '{3'b001, 3'b111, 3'b001, 1'b1, 1'b1, 2'd1};
    vec[25] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 2'd2};
    vec[26] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0};

    program_reset     = 1'b1;
    bus_a.req         = '0;
    bus_a.plot_in     = '0;
    bus_a.x_in        = x_all;
    bus_a.y_in        = y_all;
    bus_a.colour_in   = c_all;
    bus_b.req         = '0;
    bus_b.plot_in     = '0;
    bus_b.x_in        = x_all;
    bus_b.y_in        = y_all;
    bus_b.colour_in   = c_all;

    // Reset state, with a request already pending that must not be granted.
    bus_a.req = 3'b001;
    tick();
    tick();
    check_a("reset", 3'b000, 1'b0, 1'b0, 2'd0);
    bus_a.req = '0;
    program_reset = 1'b0;

    // Table: three-way round robin with turnarounds, plot gating, wrap-around.
    for (int i = 0; i < 27; i++) begin
      bus_a.req     = vec[i].req;
      bus_a.plot_in = vec[i].plot_in;
      tick();
      check_a($sformatf("row%0d", i), vec[i].grant, vec[i].plot, vec[i].busy, vec[i].state);
    end

    // Preemption after MAX_HOLD+1 grant cycles; requester 1 raised at cycle 2.
    bus_b.req = 3'b001;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) bus_b.req = 3'b011;
      tick();
      check_b($sformatf("hold%0d", c), 3'b001, 3'b000, 2'd1);
    end
    tick();
    check_b("preempt", 3'b000, 3'b001, 2'd2);
    tick();
    check_b("after_preempt", 3'b010, 3'b000, 2'd1);
    bus_b.req = 3'b001;
    tick();
    check_b("release1", 3'b000, 3'b000, 2'd2);
    tick();
    check_b("regrant0", 3'b001, 3'b000, 2'd1);
    bus_b.req = 3'b000;
    tick();
    check_b("release0", 3'b000, 3'b000, 2'd2);
    tick();
    check_b("idle_b", 3'b000, 3'b000, 2'd0);

    // Owner drops its request in the very cycle the hold limit is reached.
    bus_b.req = 3'b010;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) bus_b.req = 3'b011;
      tick();
      check_b($sformatf("rel_hold%0d", c), 3'b010, 3'b000, 2'd1);
    end
    bus_b.req = 3'b001;
    tick();
    check_b("rel_at_max", 3'b000, 3'b000, 2'd2);
    tick();
    check_b("rel_next", 3'b001, 3'b000, 2'd1);
    bus_b.req = 3'b000;
    tick();
    tick();
    check_b("idle_b2", 3'b000, 3'b000, 2'd0);

    // Asynchronous reset mid-grant, then arbitration restarts from requester 0.
    bus_a.req     = 3'b001;
    bus_a.plot_in = 3'b001;
    tick();
    check_a("pre_rst", 3'b001, 1'b1, 1'b1, 2'd1);
    #2;
    program_reset = 1'b1;
    #1;
    check_a("async_rst", 3'b000, 1'b0, 1'b0, 2'd0);
    tick();
    check_a("held_rst", 3'b000, 1'b0, 1'b0, 2'd0);
    program_reset = 1'b0;
    bus_a.req     = 3'b110;
    bus_a.plot_in = 3'b010;
    tick();
    check_a("post_rst", 3'b010, 1'b1, 1'b1, 2'd1);
    bus_a.req = 3'b000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
